multi_lights_selector: RTL and testbench
========================================

# multi_lights_selector

Parametrised N-channel successor to the single-channel lights selector: each channel holds a 3-bit colour state advanced by a debounced-edge button or an auto-advance dwell timer, maps it to 24-bit RGB, and muxes against a forced-white override. Sits between the board buttons/switches and the LED driver, replacing the separate colour counter, converter and selector chain with one registered block.

## Interface
- CHANNELS, 4, number of independent light channels (1..16)
- DWELL_W, 8, width of the auto-advance dwell count
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- enable  input  1  global run enable; 0 freezes all state and outputs
- mode  input  1  0 = manual (button only), 1 = auto (timer and button)
- dwell  input  DWELL_W  auto-advance period minus one, in cycles
- sel  input  CHANNELS  per channel: 1 = show colour, 0 = force white
- button  input  CHANNELS  per-channel advance button, level
- light  output  24*CHANNELS  channel c at bits [24c+23:24c], order R[23:16] G[15:8] B[7:0]
- light_changed  output  CHANNELS  one-cycle pulse when channel c's light register takes a new value

## Operation
- Colour state per channel: 3 bits, reset 0 (black). Advance: 0->1, 1->2 ... 5->6, 6->1. 7 never reached; 0 only after reset.
- Palette: bit2=R, bit1=G, bit0=B; a set bit gives component 0xFF, clear gives 0x00 (1 blue, 2 green, 3 cyan, 4 red, 5 magenta, 6 yellow).
- Output select: sel[c]=1 -> palette(colour); sel[c]=0 -> 0xFFFFFF. sel does not alter colour state.
- Button: registered copy button_q; advance request on button & ~button_q (rising edge). Held button = single advance.
- Auto mode: per-channel counter counts 0..dwell, advance at count==dwell then reload 0. Period dwell+1 cycles; dwell=0 advances every cycle. In manual mode counters held at 0.
- Button edge in auto mode advances and reloads counter to 0. Button edge and timer expiry same cycle -> exactly one advance.
- enable=0: colour, counters, light held; button_q still tracks button (edges during disable are lost, no deferred advance); light_changed = 0.
- Mode change 1->0 clears counters next cycle; 0->1 starts from 0.
- Mid-operation reset: all state returns to reset values on the next edge regardless of enable.

## Timing
- Reset values: light = 0 (all channels, even with sel=0), light_changed = 0, colour = 0, counters = 0, button_q = 0.
- Button rises before edge k: colour updates at edge k, light at edge k+1, light_changed high cycle after k+1.
- sel change before edge k: light updates at edge k (one-cycle latency).
- light_changed[c] = 1 for exactly the cycle following an edge where light[c] changed value; no pulse if new value equals old (e.g. sel=0 while colour advances).
- First cycle after rst deasserts: light reflects sel/colour at that edge (sel=0 -> 0xFFFFFF).

## Configuration
- LIGHTS_BRIGHTNESS_EN defined: adds input brightness [7:0]; set palette bits give component = brightness instead of 0xFF; forced white = {3{brightness}}. brightness change propagates to light in one cycle and pulses light_changed.
- Undefined: no brightness port, components fixed at 0xFF/0x00.

## Structure
- Package lights_pkg: colour_t (3-bit), RGB_W = 24, COLOUR_FIRST = 1, COLOUR_LAST = 6, WHITE = 24'hFFFFFF, palette function colour -> RGB.
- One sub-module light_channel (edge detect, dwell counter, colour state, output register, change pulse), generated CHANNELS times; top holds only shared inputs and output packing.

## Test plan
- Reset with sel=all 1 -> light = 0 every channel; release rst with sel[0]=0 -> light[23:0] = 0xFFFFFF one edge later, light_changed[0] pulse.
- Manual, sel=1, press button[1] six times (2-cycle pulses) -> channel 1 light 0x0000FF, 0x00FF00, 0x00FFFF, 0xFF0000, 0xFF00FF, 0xFFFF00; seventh press -> 0x0000FF; other channels stay 0.
- Hold button[2] high 20 cycles -> exactly one advance, one light_changed[2] pulse.
- Auto, dwell=3 -> each channel advances every 4 cycles; button edge on same cycle as expiry -> one advance only.
- enable=0 for 10 cycles with button toggles and auto mode -> light unchanged, no pulses; enable=1 resumes from held colour.
- With LIGHTS_BRIGHTNESS_EN, brightness=0x40, colour 5 -> light 0x400040; sel=0 -> 0x404040.

Source files
------------

// File: rtl/lights_pkg.sv
// Shared types, constants and palette for the multi-channel lights selector.
package lights_pkg;

  typedef logic [2:0] colour_t;

  localparam int RGB_W = 24;
  localparam colour_t COLOUR_FIRST = 3'd1;
  localparam colour_t COLOUR_LAST  = 3'd6;
  localparam logic [RGB_W-1:0] WHITE = 24'hFFFFFF;

  // bit2 drives red, bit1 green, bit0 blue; a set bit lights its component at 'level'
  function automatic logic [RGB_W-1:0] palette(input colour_t c, input logic [7:0] level);
    return {(c[2] ? level : 8'h00), (c[1] ? level : 8'h00), (c[0] ? level : 8'h00)};
  endfunction

  // 0 (post-reset black) and the last colour both wrap back to the first colour
  function automatic colour_t next_colour(input colour_t c);
    return ((c == 3'd0) || (c >= COLOUR_LAST)) ? COLOUR_FIRST : colour_t'(c + 3'd1);
  endfunction

endpackage

// File: rtl/multi_lights_selector_if.sv
// Control/light bus between board inputs and the selector. Optional macro: LIGHTS_BRIGHTNESS_EN.
interface multi_lights_selector_if #(
  parameter int CHANNELS = 4,
  parameter int DWELL_W  = 8
);
  logic                     enable;
  logic                     mode;
  logic [DWELL_W-1:0]       dwell;
  logic [CHANNELS-1:0]      sel;
  logic [CHANNELS-1:0]      button;
`ifdef LIGHTS_BRIGHTNESS_EN
  logic [7:0]               brightness;
`endif
  logic [24*CHANNELS-1:0]   light;
  logic [CHANNELS-1:0]      light_changed;

`ifdef LIGHTS_BRIGHTNESS_EN
  modport master (output enable, mode, dwell, sel, button, brightness,
                  input  light, light_changed);
  modport slave  (input  enable, mode, dwell, sel, button, brightness,
                  output light, light_changed);
`else
  modport master (output enable, mode, dwell, sel, button,
                  input  light, light_changed);
  modport slave  (input  enable, mode, dwell, sel, button,
                  output light, light_changed);
`endif
endinterface

// File: rtl/multi_lights_selector_light_channel.sv
// One light channel: button edge detect, auto-advance dwell counter, colour state,
// registered RGB output and change pulse.
module light_channel
  import lights_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               sel,
  input  logic               button,
  input  logic [7:0]         level,
  output logic [RGB_W-1:0]   light,
  output logic               light_changed
);

  logic               button_q;
  colour_t            colour_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [RGB_W-1:0]   light_p1;
  logic               changed_p1;

  logic               press;
  logic               expire;
  logic               advance;
  logic [RGB_W-1:0]   light_d;

  always_comb begin
    press   = button & ~button_q;
    expire  = mode & (cnt_q == dwell);
    advance = press | expire;
    light_d = sel ? palette(colour_q, level) : {3{level}};
  end

  // Stage p1: colour/counter update and output register; button_q keeps tracking while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      button_q   <= 1'b0;
      colour_q   <= '0;
      cnt_q      <= '0;
      light_p1   <= '0;
      changed_p1 <= 1'b0;
    end else begin
      button_q <= button;
      if (enable) begin
        if (advance)
          colour_q <= next_colour(colour_q);
        if (!mode || advance)
          cnt_q <= '0;
        else
          cnt_q <= cnt_q + DWELL_W'(1);
        light_p1   <= light_d;
        changed_p1 <= (light_d != light_p1);
      end else begin
        changed_p1 <= 1'b0;
      end
    end
  end

  assign light         = light_p1;
  assign light_changed = changed_p1;

endmodule

// File: rtl/multi_lights_selector.sv
// N-channel lights selector top: shared inputs fanned out to CHANNELS light_channel
// instances, outputs packed per channel. Optional macro: LIGHTS_BRIGHTNESS_EN.
module multi_lights_selector
  import lights_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DWELL_W  = 8
) (
  input logic                     clk,
  input logic                     rst,
  multi_lights_selector_if.slave  bus
);

  logic [7:0] level;

`ifdef LIGHTS_BRIGHTNESS_EN
  assign level = bus.brightness;
`else
  assign level = WHITE[7:0];
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    light_channel #(
      .DWELL_W (DWELL_W)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .enable        (bus.enable),
      .mode          (bus.mode),
      .dwell         (bus.dwell),
      .sel           (bus.sel[c]),
      .button        (bus.button[c]),
      .level         (level),
      .light         (bus.light[RGB_W*c +: RGB_W]),
      .light_changed (bus.light_changed[c])
    );
  end

endmodule

// File: tb/tb_multi_lights_selector.sv
// Self-checking bench for multi_lights_selector with a cycle-level behavioural model.
module tb_multi_lights_selector;
  localparam int CH = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_lights_selector_if #(.CHANNELS(CH), .DWELL_W(DW)) bus ();
  multi_lights_selector #(.CHANNELS(CH), .DWELL_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // model state: colour number, dwell count, previous button, light value, change pulse
  int          m_col [CH];
  int          m_cnt [CH];
  bit          m_bq  [CH];
  logic [23:0] m_light [CH];
  bit          m_chg [CH];

  function automatic int lvl_now();
`ifdef LIGHTS_BRIGHTNESS_EN
    return int'(bus.brightness);
`else
    return 255;
`endif
  endfunction

  function automatic logic [23:0] ref_rgb(int col, int lvl);
    int r, g, b;
    r = ((col / 4) % 2) * lvl;
    g = ((col / 2) % 2) * lvl;
    b = (col % 2) * lvl;
    return 24'(r * 65536 + g * 256 + b);
  endfunction

  function automatic logic [23:0] dut_light(int c);
    return bus.light[24*c +: 24];
  endfunction

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit pressed, adv;
      logic [23:0] nl;
      if (rst) begin
        m_col[c] = 0; m_cnt[c] = 0; m_bq[c] = 0; m_light[c] = '0; m_chg[c] = 0;
      end else begin
        pressed = bus.button[c] && !m_bq[c];
        if (bus.enable) begin
          nl  = bus.sel[c] ? ref_rgb(m_col[c], lvl_now()) : 24'(lvl_now() * 65793);
          adv = pressed || (bus.mode && m_cnt[c] == int'(bus.dwell));
          m_chg[c]   = (nl != m_light[c]);
          m_light[c] = nl;
          if (adv) m_col[c] = (m_col[c] % 6) + 1;
          m_cnt[c] = (!bus.mode || adv) ? 0 : (m_cnt[c] + 1) % 256;
        end else begin
          m_chg[c] = 0;
        end
        m_bq[c] = bus.button[c];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (dut_light(c) !== 24'h000000) begin
        errors++; $display("FAIL reset_light[%0d]: got %h want 000000", c, dut_light(c));
      end
    end
    checks++;
    if (bus.light_changed !== 4'b0000) begin
      errors++; $display("FAIL reset_changed: got %b want 0000", bus.light_changed);
    end
    rst = 1'b0;
    bus.sel = 4'b1110;
    tick();
    checks++;
    if (dut_light(0) !== 24'hFFFFFF) begin
      errors++; $display("FAIL release_white: got %h want FFFFFF", dut_light(0));
    end
    checks++;
    if (dut_light(1) !== 24'h000000) begin
      errors++; $display("FAIL release_black: got %h want 000000", dut_light(1));
    end
    checks++;
    if (bus.light_changed !== 4'b0001) begin
      errors++; $display("FAIL release_pulse: got %b want 0001", bus.light_changed);
    end
    tick();
    checks++;
    if (bus.light_changed !== 4'b0000) begin
      errors++; $display("FAIL release_pulse_end: got %b want 0000", bus.light_changed);
    end
  endtask

  task automatic test_manual();
    logic [23:0] seq [6];
    seq = '{24'h0000FF, 24'h00FF00, 24'h00FFFF, 24'hFF0000, 24'hFF00FF, 24'hFFFF00};
    bus.mode = 1'b0;
    bus.sel  = 4'b1111;
    tick();
    for (int p = 0; p < 7; p++) begin
      bus.button[1] = 1'b1; tick(); tick();
      bus.button[1] = 1'b0; tick(); tick();
      checks++;
      if (dut_light(1) !== seq[p % 6]) begin
        errors++; $display("FAIL manual_press%0d: got %h want %h", p, dut_light(1), seq[p % 6]);
      end
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (dut_light(c) !== m_light[c]) begin
          errors++; $display("FAIL manual_model[%0d]: got %h want %h", c, dut_light(c), m_light[c]);
        end
      end
    end
    checks++;
    if (dut_light(3) !== 24'h000000) begin
      errors++; $display("FAIL manual_other: got %h want 000000", dut_light(3));
    end
  endtask

  task automatic test_hold();
    int pulses = 0;
    bus.button[2] = 1'b1;
    repeat (22) begin
      tick();
      pulses += int'(bus.light_changed[2]);
    end
    bus.button[2] = 1'b0;
    tick();
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL hold_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (dut_light(2) !== 24'h0000FF) begin
      errors++; $display("FAIL hold_colour: got %h want 0000FF", dut_light(2));
    end
  endtask

  task automatic test_auto();
    bus.mode  = 1'b1;
    bus.dwell = 8'd3;
    bus.sel   = 4'b1111;
    for (int t = 0; t < 16; t++) begin
      tick();
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (dut_light(c) !== m_light[c] || bus.light_changed[c] !== m_chg[c]) begin
          errors++; $display("FAIL auto_model[%0d] t%0d: got %h/%b want %h/%b",
                             c, t, dut_light(c), bus.light_changed[c], m_light[c], m_chg[c]);
        end
      end
    end
    checks++;
    if (dut_light(0) !== 24'h00FFFF) begin
      errors++; $display("FAIL auto_period: got %h want 00FFFF", dut_light(0));
    end
    repeat (3) tick();
    bus.button[3] = 1'b1;
    tick();
    tick();
    bus.button[3] = 1'b0;
    checks++;
    if (dut_light(3) !== 24'hFF00FF) begin
      errors++; $display("FAIL auto_coincide: got %h want FF00FF", dut_light(3));
    end
    checks++;
    if (dut_light(0) !== 24'hFF00FF) begin
      errors++; $display("FAIL auto_timer_only: got %h want FF00FF", dut_light(0));
    end
  endtask

  task automatic test_enable();
    logic [23:0] snap [CH];
    bus.mode  = 1'b1;
    bus.dwell = 8'd2;
    for (int c = 0; c < CH; c++) snap[c] = dut_light(c);
    bus.enable = 1'b0;
    for (int t = 0; t < 10; t++) begin
      bus.button = 4'($urandom);
      tick();
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (dut_light(c) !== snap[c] || bus.light_changed[c] !== 1'b0) begin
          errors++; $display("FAIL disable_hold[%0d] t%0d: got %h/%b want %h/0",
                             c, t, dut_light(c), bus.light_changed[c], snap[c]);
        end
      end
    end
    bus.enable = 1'b1;
    for (int t = 0; t < 12; t++) begin
      bus.button = 4'($urandom);
      tick();
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (dut_light(c) !== m_light[c] || bus.light_changed[c] !== m_chg[c]) begin
          errors++; $display("FAIL resume_model[%0d] t%0d: got %h/%b want %h/%b",
                             c, t, dut_light(c), bus.light_changed[c], m_light[c], m_chg[c]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      bus.button = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.sel = 4'($urandom);
      if ($urandom_range(0, 19) == 0) bus.mode = 1'($urandom);
      if ($urandom_range(0, 29) == 0) bus.dwell = 8'($urandom_range(0, 3));
      bus.enable = ($urandom_range(0, 9) != 0);
`ifdef LIGHTS_BRIGHTNESS_EN
      if ($urandom_range(0, 49) == 0) bus.brightness = 8'($urandom);
`endif
      tick();
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (dut_light(c) !== m_light[c] || bus.light_changed[c] !== m_chg[c]) begin
          errors++; $display("FAIL random_model[%0d] t%0d: got %h/%b want %h/%b",
                             c, t, dut_light(c), bus.light_changed[c], m_light[c], m_chg[c]);
        end
      end
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_mid_reset();
    bus.enable = 1'b0;
    bus.sel    = 4'b0000;
    rst = 1'b1;
    tick();
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (dut_light(c) !== 24'h000000 || bus.light_changed[c] !== 1'b0) begin
        errors++; $display("FAIL mid_reset[%0d]: got %h/%b want 000000/0",
                           c, dut_light(c), bus.light_changed[c]);
      end
    end
    rst = 1'b0;
    bus.enable = 1'b1;
    bus.sel    = 4'b1111;
    bus.mode   = 1'b0;
    bus.button = '0;
    tick();
  endtask

`ifdef LIGHTS_BRIGHTNESS_EN
  task automatic test_brightness();
    bus.brightness = 8'h40;
    for (int p = 0; p < 5; p++) begin
      bus.button[0] = 1'b1; tick(); tick();
      bus.button[0] = 1'b0; tick(); tick();
    end
    checks++;
    if (dut_light(0) !== 24'h400040) begin
      errors++; $display("FAIL bright_colour: got %h want 400040", dut_light(0));
    end
    bus.sel[0] = 1'b0;
    tick();
    checks++;
    if (dut_light(0) !== 24'h404040 || bus.light_changed[0] !== 1'b1) begin
      errors++; $display("FAIL bright_white: got %h/%b want 404040/1",
                         dut_light(0), bus.light_changed[0]);
    end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    bus.enable = 1'b1;
    bus.mode   = 1'b0;
    bus.dwell  = '0;
    bus.sel    = '1;
    bus.button = '0;
`ifdef LIGHTS_BRIGHTNESS_EN
    bus.brightness = 8'hFF;
`endif
    test_reset();
    test_manual();
    test_hold();
    test_auto();
    test_enable();
    test_random();
    test_mid_reset();
`ifdef LIGHTS_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
